// File: rtl/rtlinf_pkg.sv
// Shared state encoding and default widths for the read sequencer.
package rtlinf_pkg;
  localparam int LOG_MAX_ITERS          = 8;
  localparam int LOG_MAX_READS_PER_ITER = 8;
  localparam int LOG_MAX_ADDRESS        = 12;

  typedef enum logic [2:0] {
    IDLE,
    W_REQ,
    W_WAIT,
    A_READ,
    FINISH
  } state_t;
endpackage

// File: rtl/read_sequencer.sv
// Read sequencer: per iteration, fetch one weight row, wait for it, then
// stream a block of activation reads paced by downstream ready.
module read_sequencer #(
  parameter int LOG_MAX_ITERS          = rtlinf_pkg::LOG_MAX_ITERS,
  parameter int LOG_MAX_READS_PER_ITER = rtlinf_pkg::LOG_MAX_READS_PER_ITER,
  parameter int LOG_MAX_ADDRESS        = rtlinf_pkg::LOG_MAX_ADDRESS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic [LOG_MAX_ADDRESS-1:0]        read_address,
  output logic                              weight_read,
  output logic [LOG_MAX_ADDRESS-1:0]        weight_addr,
  input  logic                              weight_valid,
  output logic                              act_read,
  output logic [LOG_MAX_ADDRESS-1:0]        act_addr,
  input  logic                              ready,
  output logic                              last_read,
  output logic [LOG_MAX_ITERS-1:0]          iter_idx,
  output logic                              busy,
  output logic                              done
);
  import rtlinf_pkg::*;

  localparam int LI = LOG_MAX_ITERS;
  localparam int LR = LOG_MAX_READS_PER_ITER;
  localparam int LA = LOG_MAX_ADDRESS;

  // One extra bit so a zero input (meaning 2^W) is representable.
  localparam logic [LI:0] ITER_ONE = (LI+1)'(1);
  localparam logic [LR:0] READ_ONE = (LR+1)'(1);

  state_t      state, state_nx;
  logic [LI:0] iter_cnt, n_iters;
  logic [LR:0] k, n_reads;
  logic [LA-1:0] base;

  assign iter_idx    = iter_cnt[LI-1:0];
  assign weight_read = (state == W_REQ);
  assign weight_addr = LA'(iter_idx);
  assign act_read    = (state == A_READ) && ready;
  assign act_addr    = base + LA'(k);
  assign last_read   = act_read && (k == n_reads - READ_ONE);
  assign busy        = (state == W_REQ) || (state == W_WAIT) || (state == A_READ);
  assign done        = (state == FINISH);

  // State register plus configuration latch and the two counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      iter_cnt <= '0;
      k        <= '0;
      n_iters  <= '0;
      n_reads  <= '0;
      base     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && configure) begin
        n_iters  <= {num_iters == '0, num_iters};
        n_reads  <= {num_reads_per_iter == '0, num_reads_per_iter};
        base     <= read_address;
        iter_cnt <= '0;
      end
      if (state == W_WAIT && weight_valid)
        k <= '0;
      if (act_read) begin
        if (last_read) begin
          k        <= '0;
          iter_cnt <= iter_cnt + ITER_ONE;
        end else begin
          k <= k + READ_ONE;
        end
      end
    end
  end

  // Next-state decode; only IDLE listens to configure.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (configure) state_nx = W_REQ;
      W_REQ:   state_nx = W_WAIT;
      W_WAIT:  if (weight_valid) state_nx = A_READ;
      A_READ:  if (last_read)
                 state_nx = (iter_cnt + ITER_ONE == n_iters) ? FINISH : W_REQ;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule
